// File: rtl/serial_transmitter.sv
// LSB-first parallel-to-serial transmitter with load/ready handshake and a bit-rate strobe.
// Optional even-parity bit appended per frame when SERIAL_TRANSMITTER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | no frame in flight, ready for a word, serial_data low
// SHIFT  | data bits presented one per shift_enable strobe
// PARITY | even-parity bit presented (SERIAL_TRANSMITTER_PARITY_EN only)
module serial_transmitter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] parallel_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_enable,
    output logic             serial_data,
    output logic             bit_valid,
    output logic             frame_done
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]       state;
    logic [CW-1:0]    bit_count;
    logic [WIDTH-1:0] shift_reg;
    logic             serial_q;
    logic             done_q;
    logic             at_last;
    logic             frame_end;
    logic             accept;

    assign at_last = (state == SHIFT) && (bit_count == LAST_BIT);

`ifdef SERIAL_TRANSMITTER_PARITY_EN
    logic parity_q;
    assign frame_end = (state == PARITY) && shift_enable;
`else
    assign frame_end = at_last && shift_enable;
`endif

    // The final bit of a frame being consumed is the only point a new word may chain in.
    assign load_ready  = (state == IDLE) || frame_end;
    assign accept      = load_valid && load_ready;
    assign bit_valid   = (state != IDLE);
    assign serial_data = serial_q;
    assign frame_done  = done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_count <= '0;
            shift_reg <= '0;
            serial_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= frame_end;
            if (accept) begin
                state     <= SHIFT;
                serial_q  <= parallel_data[0];
                shift_reg <= parallel_data >> 1;
                bit_count <= '0;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                parity_q  <= ^parallel_data;
`endif
            end else if (shift_enable) begin
                case (state)
                    SHIFT: begin
                        if (at_last) begin
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                            state    <= PARITY;
                            serial_q <= parity_q;
`else
                            state    <= IDLE;
                            serial_q <= 1'b0;
`endif
                            bit_count <= '0;
                        end else begin
                            serial_q  <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_count <= bit_count + 1'b1;
                        end
                    end
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                    PARITY: begin
                        state    <= IDLE;
                        serial_q <= 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Self-checking bench for serial_transmitter: directed tables, corner sequences and
// randomized traffic compared against a bit-queue reference model.
module tb_serial_transmitter;

    localparam int W = 8;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clock = 1'b0;
    logic         reset_n;
    logic [W-1:0] parallel_data;
    logic         load_valid;
    logic         load_ready;
    logic         shift_enable;
    logic         serial_data;
    logic         bit_valid;
    logic         frame_done;

    always #5 clock = ~clock;

    serial_transmitter #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .parallel_data (parallel_data),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .shift_enable  (shift_enable),
        .serial_data   (serial_data),
        .bit_valid     (bit_valid),
        .frame_done    (frame_done)
    );

    typedef struct {
        logic         lv;
        logic [W-1:0] data;
        logic         se;
        logic         exp_lr;
        logic         exp_sd;
        logic         exp_bv;
        logic         exp_fd;
    } vec_t;

    vec_t tbl[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cnt_bv      = 0;
    int   cnt_fd      = 0;

    // Reference model: bits still to be shown for the frame in flight, head is on the wire.
    logic exp_q[$];
    logic exp_fd = 1'b0;

    function automatic logic m_ready(input logic se);
        return (exp_q.size() == 0) || (exp_q.size() == 1 && se);
    endfunction

    task automatic model_edge(input logic lv, input logic [W-1:0] d, input logic se);
        logic acc;
        acc    = lv && m_ready(se);
        exp_fd = (exp_q.size() == 1) && se;
        if (exp_q.size() > 0 && se) void'(exp_q.pop_front());
        if (acc) begin
            for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
`ifdef SERIAL_TRANSMITTER_PARITY_EN
            exp_q.push_back(^d);
`endif
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Starts and ends at posedge+1.
    task automatic step(input logic lv, input logic [W-1:0] d, input logic se,
                        output logic o_lr, output logic o_sd, output logic o_bv, output logic o_fd);
        load_valid    = lv;
        parallel_data = d;
        shift_enable  = se;
        #1;
        o_lr = load_ready;
        chk("load_ready", load_ready, m_ready(se));
        @(posedge clock);
        model_edge(lv, d, se);
        #1;
        o_sd = serial_data;
        o_bv = bit_valid;
        o_fd = frame_done;
        chk("serial_data", serial_data, (exp_q.size() > 0) ? exp_q[0] : 1'b0);
        chk("bit_valid", bit_valid, exp_q.size() > 0);
        chk("frame_done", frame_done, exp_fd);
        if (bit_valid) cnt_bv++;
        if (frame_done) cnt_fd++;
    endtask

    task automatic st(input logic lv, input logic [W-1:0] d, input logic se);
        logic a, b, c, e;
        step(lv, d, se, a, b, c, e);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) st(1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_serial_data", serial_data, 1'b0);
        chk("rst_bit_valid", bit_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_load_ready", load_ready, 1'b1);
        exp_q.delete();
        exp_fd = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_hold_bit_valid", bit_valid, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic add(input logic lv, input logic [W-1:0] d, input logic se,
                       input logic lr, input logic sd, input logic bv, input logic fd);
        vec_t v;
        v.lv = lv; v.data = d; v.se = se;
        v.exp_lr = lr; v.exp_sd = sd; v.exp_bv = bv; v.exp_fd = fd;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lr, sd, bv, fd;

        // 0xA5 with shift_enable high: bits 1,0,1,0,0,1,0,1 LSB first
        add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef SERIAL_TRANSMITTER_PARITY_EN
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        reset_n       = 1'b0;
        load_valid    = 1'b0;
        shift_enable  = 1'b0;
        parallel_data = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("init_serial_data", serial_data, 1'b0);
        chk("init_bit_valid", bit_valid, 1'b0);
        chk("init_frame_done", frame_done, 1'b0);
        chk("init_load_ready", load_ready, 1'b1);
        reset_n = 1'b1;

        cnt_fd = 0;
        foreach (tbl[i]) begin
            step(tbl[i].lv, tbl[i].data, tbl[i].se, lr, sd, bv, fd);
            chk($sformatf("tbl%0d_load_ready", i), lr, tbl[i].exp_lr);
            chk($sformatf("tbl%0d_serial_data", i), sd, tbl[i].exp_sd);
            chk($sformatf("tbl%0d_bit_valid", i), bv, tbl[i].exp_bv);
            chk($sformatf("tbl%0d_frame_done", i), fd, tbl[i].exp_fd);
        end
        chk_int("a5_frame_done_count", cnt_fd, 1);

        // Back-to-back: 0x3C then 0xFF with load_valid held high
        cnt_bv = 0; cnt_fd = 0;
        st(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < W + P; i++) st(1'b1, 8'hFF, 1'b1);
        idle_steps(W + P + 2);
        chk_int("b2b_valid_bits", cnt_bv, 2 * (W + P));
        chk_int("b2b_frame_done_count", cnt_fd, 2);

        // Stall: 0x81, shift_enable low for 3 cycles while bit 2 is shown
        cnt_bv = 0; cnt_fd = 0;
        st(1'b1, 8'h81, 1'b1);
        st(1'b0, '0, 1'b1);
        st(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, lr, sd, bv, fd);
            chk("stall_hold_bit2", sd, 1'b0);
        end
        idle_steps(W + P + 2);
        chk_int("stall_valid_cycles", cnt_bv, 11 + P);
        chk_int("stall_frame_done_count", cnt_fd, 1);

        // Busy load ignored: 0x00 offered during a 0xF0 frame
        cnt_bv = 0; cnt_fd = 0;
        st(1'b1, 8'hF0, 1'b1);
        st(1'b0, '0, 1'b1);
        st(1'b0, '0, 1'b1);
        st(1'b1, 8'h00, 1'b1);
        idle_steps(W + P + 4);
        chk_int("busy_valid_bits", cnt_bv, W + P);
        chk_int("busy_frame_done_count", cnt_fd, 1);

        // Reset while bit 4 of 0x55 is on the wire
        cnt_fd = 0;
        st(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) st(1'b0, '0, 1'b1);
        do_reset();
        chk_int("reset_no_frame_done", cnt_fd, 0);
        st(1'b1, 8'h01, 1'b1);
        idle_steps(W + P + 2);
        chk_int("post_reset_frame_done", cnt_fd, 1);

`ifdef SERIAL_TRANSMITTER_PARITY_EN
        cnt_fd = 0;
        st(1'b1, 8'h07, 1'b1);
        for (int i = 0; i < W; i++) step(1'b0, '0, 1'b1, lr, sd, bv, fd);
        chk("parity_07_bit", sd, 1'b1);
        chk("parity_07_valid", bv, 1'b1);
        idle_steps(2);
        chk_int("parity_07_frame_done", cnt_fd, 1);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                st(($urandom_range(0, 1) == 1), W'($urandom), ($urandom_range(0, 3) != 0));
            end
        end
        idle_steps(W + P + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. The ports are clock and reset_n.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 parallel_data  input  WIDTH  word to serialize; sampled only on an accepted load.
REQ-006 load_valid  input  1  parallel_data is valid.
REQ-007 load_ready  output  1  block can accept a word; a load is accepted when load_valid && load_ready at a rising edge.
REQ-008 shift_enable  input  1  bit-rate strobe; the current bit advances only when this is high.
REQ-009 serial_data  output  1  current serial bit, registered.
REQ-010 bit_valid  output  1  serial_data holds a frame bit; the far-end receiver shifts on bit_valid && shift_enable.
REQ-011 frame_done  output  1  one-cycle pulse after the final bit of a frame is consumed.

Function
REQ-012 States SHALL be IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
REQ-013 IDLE: load_ready=1, bit_valid=0, serial_data=0. An accepted load SHALL enter SHIFT. It captures parallel_data into the shift register and clears the bit counter.
REQ-014 Bit order SHALL be LSB-first: in the cycle after acceptance, serial_data = parallel_data[0] and bit_valid=1.
REQ-015 SHIFT: on each edge with shift_enable=1, serial_data SHALL advance to the next bit and the counter SHALL increment. With shift_enable=0, serial_data, the counter and the state SHALL hold.
REQ-016 The counter SHALL be ceil(log2(WIDTH)) bits wide. The last bit is counter==WIDTH-1.
REQ-017 In SHIFT, load_ready SHALL be combinational: 1 only when counter==WIDTH-1 && shift_enable==1 (and PARITY_EN is undefined); otherwise 0.
REQ-018 Last bit consumed with no new load: the block SHALL go to IDLE and pulse frame_done on the next cycle.
REQ-019 Last bit consumed with a load accepted on the same edge: the block SHALL stay in SHIFT and present the new word's bit 0 on the next cycle with no gap. frame_done SHALL still pulse.
REQ-020 load_valid while load_ready=0 SHALL be ignored and SHALL NOT corrupt the frame in flight.
REQ-021 Changes on parallel_data after acceptance SHALL have no effect.
REQ-022 frame_done SHALL NOT assert in any cycle other than those defined in REQ-018, REQ-019 and REQ-028.

Reset
REQ-023 Asserting reset_n=0 SHALL immediately force the following: state=IDLE, load_ready=1, bit_valid=0, serial_data=0, frame_done=0, counter=0, shift register=0.
REQ-024 Reset mid-frame SHALL abandon the frame with no frame_done. After release, the first accepted load SHALL start a clean frame.
REQ-025 Deassertion SHALL take effect at the next rising edge; there is no internal synchronizer.

Configuration
REQ-026 Macro: SERIAL_TRANSMITTER_PARITY_EN.
REQ-027 When the macro is undefined, a frame SHALL be exactly WIDTH bits and there SHALL be no PARITY state or logic.
REQ-028 When the macro is defined, after the last data bit is consumed the block SHALL enter PARITY.
  - In PARITY, bit_valid=1 and serial_data = XOR of all captured data bits (even parity).
  - The parity bit SHALL obey the same shift_enable hold rule.
  - load_ready SHALL be 1 only while in PARITY with shift_enable=1.
  - When the parity bit is consumed, REQ-018 and REQ-019 apply with "parity bit" in place of "last bit".
  - The frame SHALL be WIDTH+1 bits.

Verification
REQ-029 Basic frame (WIDTH=8): load 0xA5 with shift_enable held at 1 -> serial_data 1,0,1,0,0,1,0,1 over 8 cycles with bit_valid=1. frame_done pulses once, then the block returns to IDLE with load_ready=1.
REQ-030 Back-to-back: 0x3C with load_valid held high, followed by 0xFF -> 16 consecutive valid bits 0,0,1,1,1,1,0,0,1,1,1,1,1,1,1,1 with no bit_valid gap. Two frame_done pulses.
REQ-031 Stall: load 0x81 and drop shift_enable for 3 cycles after bit 2 -> serial_data holds 0 for 4 cycles. Total frame is 11 cycles, and bit order is unchanged.
REQ-032 Busy load ignored: pulse load_valid with 0x00 during a 0xF0 frame -> output is exactly 0,0,0,0,1,1,1,1 and no second frame follows.
REQ-033 Reset mid-frame: assert reset_n at bit 4 of 0x55 -> outputs match REQ-023 immediately and no frame_done. A subsequent load of 0x01 transmits correctly.
REQ-034 Parity, with SERIAL_TRANSMITTER_PARITY_EN defined:
  - 0xA5 -> 9 bits ending with parity 0.
  - 0x07 -> 9 bits ending with parity 1.
  - frame_done pulses after the parity bit in each case.
